pipe_mux_n: RTL

//  Parametrised, registered N:1 data selector with valid/ready handshake on every input and on the output.

---
 rtl/pipe_mux_n_if.sv | 26 ++
 rtl/pipe_mux_n.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipe_mux_n_if.sv
// Handshake bundle for pipe_mux_n: N flattened input channels,
// channel select and one registered output channel.
interface pipe_mux_n_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] In;
    logic [NUM_IN-1:0]       In_valid;
    logic [NUM_IN-1:0]       In_ready;
    logic [SEL_W-1:0]        Sel;
    logic [WIDTH-1:0]        Out;
    logic                    Out_valid;
    logic                    Out_ready;
    logic [SEL_W-1:0]        Out_src;

    modport master (
        output In, In_valid, Sel, Out_ready,
        input  In_ready, Out, Out_valid, Out_src
    );

    modport slave (
        input  In, In_valid, Sel, Out_ready,
        output In_ready, Out, Out_valid, Out_src
    );
endinterface

// File: rtl/pipe_mux_n.sv
// Registered N:1 selector with valid/ready on every channel.
// Define PIPE_MUX_RR_EN for round-robin grant instead of Sel.
module pipe_mux_n #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input logic        Clk,
    input logic        Rst_n,
    pipe_mux_n_if.slave bus
);
    logic [SEL_W-1:0] sel_eff;
    logic             sel_ok;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] data_sel;
    logic             valid_sel;

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;

`ifdef PIPE_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // first valid channel at or above ptr, wrapping
    always_comb begin
        int idx;
        idx     = 0;
        sel_eff = ptr_q;
        sel_ok  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!sel_ok && bus.In_valid[idx]) begin
                sel_eff = SEL_W'(idx);
                sel_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (int'(sel_eff) == NUM_IN - 1) ptr_d = '0;
            else ptr_d = sel_eff + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
`else
    assign sel_eff = bus.Sel;
    assign sel_ok  = int'(bus.Sel) < NUM_IN;
`endif

    assign load = ~out_valid_q | bus.Out_ready;

    always_comb begin
        data_sel  = '0;
        valid_sel = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_eff == SEL_W'(i)) begin
                data_sel  = bus.In[i*WIDTH +: WIDTH];
                valid_sel = bus.In_valid[i];
            end
        end
    end

    always_comb begin
        bus.In_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            bus.In_ready[i] = Rst_n & load & sel_ok
                            & (sel_eff == SEL_W'(i));
        end
    end

    assign accept = load & sel_ok & valid_sel;

    // a stalled word is never overwritten
    always_comb begin
        out_d       = out_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = accept;
            if (accept) begin
                out_d     = data_sel;
                out_src_d = sel_eff;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.Out       = out_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.Out_src   = out_src_q;
endmodule
